// File: rtl/demod_segment_correlator.sv
// Purpose : correlates a sample stream against a reference waveform over a bit period and decides the bit.
// Latency : result valid on the 2nd rising edge after the edge that accepts the last sample of a bit.
// Backpressure: one-entry output register; a decision arriving while it is full and not drained is dropped (sticky overflow).
//
// Ports:
//   clk, reset            - single clock, asynchronous active-low reset
//   in_valid, bit_start   - sample qualifier and first-sample-of-bit marker
//   sample, array_ref_wire- signed DATA_W received sample and paired reference sample
//   out_valid, out_ready  - held-result handshake to the consumer
//   bit_out, corr_out     - decided bit (1 = matches -ref) and signed correlation sum
//   overflow, misalign    - sticky error flags, cleared only by reset
module demod_segment_correlator #(
    parameter int SAMPLES_PER_BIT = 8,
    parameter int DATA_W          = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  bit_start,
    input  logic [DATA_W-1:0]     sample,
    input  logic [DATA_W-1:0]     array_ref_wire,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  bit_out,
    output logic [2*DATA_W+7:0]   corr_out,
    output logic                  overflow,
    output logic                  misalign
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + 8;
    localparam int CNT_W  = $clog2(SAMPLES_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SAMPLES_PER_BIT - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                     run_q;
    state_t                   state_q,   state_d;
    logic [CNT_W-1:0]         cnt_q,     cnt_d;

    logic signed [PROD_W-1:0] prod_q,    prod_d;
    logic                     p1_vld_q,  p1_vld_d;
    logic                     p1_start_q, p1_start_d;
    logic                     p1_last_q, p1_last_d;

    logic signed [ACC_W-1:0]  acc_q,     acc_d;
    logic                     dec_q,     dec_d;

    logic                     ov_vld_q,  ov_vld_d;
    logic                     ov_bit_q,  ov_bit_d;
    logic [ACC_W-1:0]         ov_corr_q, ov_corr_d;
    logic                     overflow_q, overflow_d;
    logic                     misalign_q, misalign_d;

    // ------------------------------------------------------------------
    // Input acceptance and product
    // ------------------------------------------------------------------
    // run_q rises on the first edge after reset release, so the earliest
    // sample that can be accepted lands on the second edge after release.
    logic samp_acc;
    assign samp_acc = in_valid & run_q;

    // Sign-extend both operands to the product width so the multiply is
    // exact; the true product always fits in 2*DATA_W signed bits.
    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] ref_ext;
    logic signed [PROD_W-1:0] prod_full;

    assign sample_ext = $signed({{DATA_W{sample[DATA_W-1]}}, sample});
    assign ref_ext    = $signed({{DATA_W{array_ref_wire[DATA_W-1]}}, array_ref_wire});
    assign prod_full  = sample_ext * ref_ext;

    // ------------------------------------------------------------------
    // Bit framing FSM: decides which accepted samples belong to a bit and
    // tags the first and last of them.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        misalign_d = misalign_q;
        p1_vld_d   = 1'b0;
        p1_start_d = 1'b0;
        p1_last_d  = 1'b0;
        prod_d     = prod_q;

        case (state_q)
            ST_IDLE: begin
                // Samples without bit_start are dropped while idle.
                if (samp_acc && bit_start) begin
                    p1_vld_d   = 1'b1;
                    p1_start_d = 1'b1;
                    cnt_d      = CNT_W'(1);
                    state_d    = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (samp_acc) begin
                    p1_vld_d = 1'b1;
                    if (bit_start) begin
                        // Early start: abandon the partial bit and restart here.
                        p1_start_d = 1'b1;
                        cnt_d      = CNT_W'(1);
                        misalign_d = 1'b1;
                    end else if (cnt_q == LAST_IDX) begin
                        p1_last_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (samp_acc) begin
            prod_d = prod_full;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator: a start product loads, others add.
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] prod_acc_ext;
    assign prod_acc_ext = $signed({{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q});

    always_comb begin
        acc_d = acc_q;
        if (p1_vld_q) begin
            if (p1_start_q) begin
                acc_d = prod_acc_ext;
            end else begin
                acc_d = acc_q + prod_acc_ext;
            end
        end
        // The final sum is in acc_q one cycle after the last product lands.
        dec_d = p1_vld_q & p1_last_q;
    end

    // ------------------------------------------------------------------
    // Output holding register
    // ------------------------------------------------------------------
    always_comb begin
        ov_vld_d   = ov_vld_q;
        ov_bit_d   = ov_bit_q;
        ov_corr_d  = ov_corr_q;
        overflow_d = overflow_q;

        if (dec_q) begin
            // A drain in the same cycle frees the slot for the new decision.
            if (!ov_vld_q || out_ready) begin
                ov_vld_d  = 1'b1;
                ov_bit_d  = acc_q[ACC_W-1];
                ov_corr_d = acc_q;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (ov_vld_q && out_ready) begin
            ov_vld_d  = 1'b0;
            ov_bit_d  = 1'b0;
            ov_corr_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q      <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            prod_q     <= '0;
            p1_vld_q   <= 1'b0;
            p1_start_q <= 1'b0;
            p1_last_q  <= 1'b0;
            acc_q      <= '0;
            dec_q      <= 1'b0;
            ov_vld_q   <= 1'b0;
            ov_bit_q   <= 1'b0;
            ov_corr_q  <= '0;
            overflow_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prod_q     <= prod_d;
            p1_vld_q   <= p1_vld_d;
            p1_start_q <= p1_start_d;
            p1_last_q  <= p1_last_d;
            acc_q      <= acc_d;
            dec_q      <= dec_d;
            ov_vld_q   <= ov_vld_d;
            ov_bit_q   <= ov_bit_d;
            ov_corr_q  <= ov_corr_d;
            overflow_q <= overflow_d;
            misalign_q <= misalign_d;
        end
    end

    assign out_valid = ov_vld_q;
    assign bit_out   = ov_bit_q;
    assign corr_out  = ov_corr_q;
    assign overflow  = overflow_q;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_demod_segment_correlator.sv
// Purpose : self-checking bench for demod_segment_correlator with a behavioural bit model.
// Latency : expects each decision visible exactly 3 bench cycles after its last sample is driven.
// Backpressure: exercises hold, drop (overflow) and same-cycle replacement of the output register.
module tb_demod_segment_correlator;

    localparam int NS = 8;
    localparam int DW = 32;
    localparam int AW = 2 * DW + 8;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          bit_start;
    logic [DW-1:0] sample;
    logic [DW-1:0] array_ref_wire;
    logic          out_valid;
    logic          out_ready;
    logic          bit_out;
    logic [AW-1:0] corr_out;
    logic          overflow;
    logic          misalign;

    demod_segment_correlator #(
        .SAMPLES_PER_BIT(NS),
        .DATA_W         (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .bit_start     (bit_start),
        .sample        (sample),
        .array_ref_wire(array_ref_wire),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .bit_out       (bit_out),
        .corr_out      (corr_out),
        .overflow      (overflow),
        .misalign      (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic          b;
        logic [AW-1:0] corr;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic rdy    = 1'b1;
    logic mon_en = 1'b1;

    // Behavioural model of the bit being assembled.
    logic                m_active = 1'b0;
    int                  m_cnt    = 0;
    logic signed [AW-1:0] m_sum   = '0;
    logic                m_mis    = 1'b0;

    logic          rv;
    logic          rbs;
    logic [DW-1:0] rs;
    logic [DW-1:0] rr;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_active = 1'b0;
        m_cnt    = 0;
        m_sum    = '0;
        m_mis    = 1'b0;
        q.delete();
    endfunction

    function automatic void model_accept(input logic bs, input logic [DW-1:0] s, input logic [DW-1:0] r);
        logic signed [AW-1:0] p;
        exp_t e;
        p = $signed({{(AW - DW){s[DW-1]}}, s}) * $signed({{(AW - DW){r[DW-1]}}, r});
        if (bs) begin
            if (m_active) m_mis = 1'b1;
            m_active = 1'b1;
            m_cnt    = 1;
            m_sum    = p;
        end else if (m_active) begin
            m_sum = m_sum + p;
            m_cnt = m_cnt + 1;
        end
        if (m_active && m_cnt == NS) begin
            e.due  = cyc + 3;
            e.b    = (m_sum < 0);
            e.corr = m_sum;
            q.push_back(e);
            m_active = 1'b0;
        end
    endfunction

    // Runs with out_ready held high: every decision must appear for exactly
    // one cycle at its due time, and out_valid must be low otherwise.
    task automatic monitor();
        if (q.size() > 0 && q[0].due == cyc) begin
            chk1("out_valid_due", out_valid, 1'b1);
            chk1("bit_out", bit_out, q[0].b);
            chkw("corr_out", corr_out, q[0].corr);
            void'(q.pop_front());
        end else begin
            chk1("out_valid_idle", out_valid, 1'b0);
        end
    endtask

    task automatic cycle(input logic v, input logic bs, input logic [DW-1:0] s, input logic [DW-1:0] r);
        @(negedge clk);
        if (mon_en) monitor();
        in_valid       = v;
        bit_start      = bs;
        sample         = s;
        array_ref_wire = r;
        out_ready      = rdy;
        if (v) model_accept(bs, s, r);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0);
    endtask

    task automatic send_bit(input logic [DW-1:0] s, input logic [DW-1:0] r);
        for (int i = 0; i < NS; i++) cycle(1'b1, i == 0, s, r);
    endtask

    // Asserts reset, checks the cleared outputs, and releases on a falling
    // edge so the very next driven sample meets the 2nd edge after release.
    task automatic reset_pulse();
        reset     = 1'b0;
        in_valid  = 1'b0;
        bit_start = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_bit_out", bit_out, 1'b0);
        chkw("rst_corr_out", corr_out, '0);
        chk1("rst_overflow", overflow, 1'b0);
        chk1("rst_misalign", misalign, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b1;
        in_valid       = 1'b0;
        bit_start      = 1'b0;
        sample         = '0;
        array_ref_wire = '0;
        out_ready      = 1'b1;
        #2;
        reset_pulse();

        // Matched, inverted and zero bits; first bit starts right after release.
        send_bit(32'd1000, 32'd1000);
        idle(4);
        send_bit(-32'sd1000, 32'd1000);
        send_bit(32'd0, 32'd1000);
        idle(4);
        chk1("misalign_clean", misalign, 1'b0);
        chk1("overflow_clean", overflow, 1'b0);

        // Early bit_start on sample 5: only the 8 new samples count.
        for (int i = 0; i < 4; i++) cycle(1'b1, i == 0, 32'd700, 32'd1000);
        send_bit(-32'sd300, 32'd1000);
        idle(4);
        chk1("misalign_set", misalign, 1'b1);

        // Extreme operands with in_valid toggling: unsaturated 2^65.
        for (int i = 0; i < 2 * NS; i++) cycle(i % 2 == 0, i == 0, 32'h8000_0000, 32'h8000_0000);
        idle(4);

        // Reset during sample 4 aborts the bit; a clean bit follows.
        for (int i = 0; i < 3; i++) cycle(1'b1, i == 0, 32'd1000, 32'd1000);
        cycle(1'b1, 1'b0, 32'd1000, 32'd1000);
        #2;
        reset_pulse();
        send_bit(32'd1234, 32'd999);
        idle(4);

        // Held result with out_ready low; later decisions dropped.
        mon_en = 1'b0;
        rdy    = 1'b0;
        send_bit(32'd1000, 32'd1000);
        for (int i = 0; i < NS; i++) begin
            cycle(1'b1, i == 0, 32'd500, 32'd1000);
            if (i == 2) begin
                chk1("hold_valid", out_valid, 1'b1);
                chkw("hold_corr", corr_out, 72'sd8000000);
                chk1("hold_no_ovf", overflow, 1'b0);
            end
        end
        for (int i = 0; i < NS; i++) begin
            cycle(1'b1, i == 0, 32'd250, 32'd1000);
            if (i == 1) chk1("ovf_not_yet", overflow, 1'b0);
            if (i == 2) begin
                chk1("ovf_set", overflow, 1'b1);
                chkw("ovf_held_corr", corr_out, 72'sd8000000);
            end
        end
        idle(4);
        chk1("held_valid", out_valid, 1'b1);
        chk1("held_bit", bit_out, 1'b0);
        chkw("held_corr", corr_out, 72'sd8000000);
        chk1("ovf_sticky", overflow, 1'b1);
        rdy = 1'b1;
        idle(2);
        chk1("drained_valid", out_valid, 1'b0);
        chkw("drained_corr", corr_out, '0);
        chk1("ovf_after_drain", overflow, 1'b1);

        // Full register drained in the same cycle a new decision lands.
        reset_pulse();
        mon_en = 1'b0;
        rdy    = 1'b0;
        send_bit(32'd1000, 32'd1000);
        idle(4);
        chkw("repl_first_corr", corr_out, 72'sd8000000);
        send_bit(-32'sd1000, 32'd1000);
        idle(1);
        rdy = 1'b1;
        idle(2);
        chk1("repl_valid", out_valid, 1'b1);
        chk1("repl_bit", bit_out, 1'b1);
        chkw("repl_corr", corr_out, -72'sd8000000);
        chk1("repl_no_ovf", overflow, 1'b0);
        idle(1);
        chk1("repl_drained", out_valid, 1'b0);
        q.delete();
        mon_en = 1'b1;

        // Randomized traffic against the model with a ready consumer.
        for (int i = 0; i < 1500; i++) begin
            rv  = ($urandom_range(0, 3) != 0);
            rbs = m_active ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 2) == 0);
            rs  = $urandom;
            rr  = ($urandom_range(0, 1) == 0) ? $urandom : DW'($urandom_range(0, 2000)) - DW'(1000);
            cycle(rv, rbs, rs, rr);
        end
        idle(4);
        chk1("rand_misalign", misalign, m_mis);
        chk1("rand_overflow", overflow, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
